// File: rtl/mult_wb_arbiter_pkg.sv
// Shared types for the multiply writeback arbiter: datapath defaults and the
// packed holding-FIFO entry.
package mult_wb_arbiter_pkg;

    localparam int unsigned MWB_REG_SIZE = 32;
    localparam int unsigned MWB_REG_ADDR = 5;

    typedef struct packed {
        logic [MWB_REG_ADDR-1:0] wreg;
        logic [MWB_REG_SIZE-1:0] result;
        logic                    zero;
        logic                    overflow;
        logic                    valid;
    } mwb_entry_t;

endpackage

// File: rtl/mult_wb_fifo.sv
// Holding FIFO for multiply results that lost writeback arbitration; supports
// invalidating buffered entries whose destination is overwritten by a younger write.
module mult_wb_fifo
    import mult_wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             push_i,
    input  mwb_entry_t                       push_entry_i,
    input  logic                             pop_i,
    input  logic                             inval_i,
    input  logic [MWB_REG_ADDR-1:0]          inval_addr_i,
    output mwb_entry_t                       head_o,
    output logic [$clog2(DEPTH+1)-1:0]       count_o,
    output logic                             full_o,
    output logic                             empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    mwb_entry_t        mem_q [DEPTH];
    mwb_entry_t        mem_d [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push_ok, pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Invalidate first, then pop, then push: a pushed entry never matches the
    // invalidate address because the arbiter drops same-cycle WAW multiplies.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (inval_i && mem_q[i].valid && (mem_q[i].wreg == inval_addr_i)) begin
                mem_d[i].valid = 1'b0;
            end
        end
        if (pop_ok) begin
            mem_d[rd_ptr_q].valid = 1'b0;
            rd_ptr_d              = rd_ptr_q + PTR_W'(1);
        end
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_entry_i;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/mult_wb_arbiter.sv
// Register-file writeback arbiter: ALU first, then buffered multiply results.
// Define MULT_WB_BYPASS_EN to write an unbuffered multiply result directly.
module mult_wb_arbiter
    import mult_wb_arbiter_pkg::*;
#(
    parameter int unsigned REG_SIZE = MWB_REG_SIZE,
    parameter int unsigned REG_ADDR = MWB_REG_ADDR,
    parameter int unsigned DEPTH    = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                alu_regwrite,
    input  logic [REG_ADDR-1:0] alu_wreg,
    input  logic [REG_SIZE-1:0] alu_result,
    input  logic                mul_valid,
    input  logic [REG_ADDR-1:0] mul_wreg,
    input  logic [REG_SIZE-1:0] mul_result,
    input  logic                mul_zero,
    input  logic                mul_overflow,
    output logic                mul_stall,
    output logic                rf_we,
    output logic [REG_ADDR-1:0] rf_waddr,
    output logic [REG_SIZE-1:0] rf_wdata,
    output logic                rf_zero,
    output logic                rf_overflow
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    mwb_entry_t          push_entry;
    mwb_entry_t          head;
    logic [CNT_W-1:0]    fifo_count;
    logic                fifo_full, fifo_empty;
    logic                push, pop;
    logic                mul_acc, mul_keep;

    logic                rf_we_q, rf_we_d;
    logic [REG_ADDR-1:0] rf_waddr_q, rf_waddr_d;
    logic [REG_SIZE-1:0] rf_wdata_q, rf_wdata_d;
    logic                rf_zero_q, rf_zero_d;
    logic                rf_overflow_q, rf_overflow_d;

    assign mul_stall = (fifo_count == CNT_W'(DEPTH));

    // A multiply to r0, or to the same register as a concurrent ALU write, is dropped.
    assign mul_acc  = mul_valid && !fifo_full;
    assign mul_keep = mul_acc && (mul_wreg != '0)
                      && !(alu_regwrite && (alu_wreg == mul_wreg));

    always_comb begin
        push_entry          = '0;
        push_entry.wreg     = mul_wreg;
        push_entry.result   = mul_result;
        push_entry.zero     = mul_zero;
        push_entry.overflow = mul_overflow;
        push_entry.valid    = 1'b1;
    end

    always_comb begin
        rf_we_d       = 1'b0;
        rf_waddr_d    = '0;
        rf_wdata_d    = '0;
        rf_zero_d     = 1'b0;
        rf_overflow_d = 1'b0;
        pop           = 1'b0;
        push          = mul_keep;
        if (alu_regwrite) begin
            if (alu_wreg != '0) begin
                rf_we_d    = 1'b1;
                rf_waddr_d = alu_wreg;
                rf_wdata_d = alu_result;
            end
        end else if (!fifo_empty) begin
            pop = 1'b1;
            if (head.valid && (head.wreg != '0)) begin
                rf_we_d       = 1'b1;
                rf_waddr_d    = head.wreg;
                rf_wdata_d    = head.result;
                rf_zero_d     = head.zero;
                rf_overflow_d = head.overflow;
            end
        end
`ifdef MULT_WB_BYPASS_EN
        else if (mul_keep) begin
            push          = 1'b0;
            rf_we_d       = 1'b1;
            rf_waddr_d    = mul_wreg;
            rf_wdata_d    = mul_result;
            rf_zero_d     = mul_zero;
            rf_overflow_d = mul_overflow;
        end
`endif
    end

    mult_wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .inval_i      (alu_regwrite),
        .inval_addr_i (alu_wreg),
        .head_o       (head),
        .count_o      (fifo_count),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we_q       <= 1'b0;
            rf_waddr_q    <= '0;
            rf_wdata_q    <= '0;
            rf_zero_q     <= 1'b0;
            rf_overflow_q <= 1'b0;
        end else begin
            rf_we_q       <= rf_we_d;
            rf_waddr_q    <= rf_waddr_d;
            rf_wdata_q    <= rf_wdata_d;
            rf_zero_q     <= rf_zero_d;
            rf_overflow_q <= rf_overflow_d;
        end
    end

    assign rf_we       = rf_we_q;
    assign rf_waddr    = rf_waddr_q;
    assign rf_wdata    = rf_wdata_q;
    assign rf_zero     = rf_zero_q;
    assign rf_overflow = rf_overflow_q;

endmodule

// File: tb/tb_mult_wb_arbiter.sv
// Directed self-checking bench for mult_wb_arbiter (DEPTH=2, 32-bit data, 5-bit addresses).
module tb_mult_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_regwrite;
    logic [4:0]  alu_wreg;
    logic [31:0] alu_result;
    logic        mul_valid;
    logic [4:0]  mul_wreg;
    logic [31:0] mul_result;
    logic        mul_zero;
    logic        mul_overflow;
    logic        mul_stall;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        rf_zero;
    logic        rf_overflow;

    int checks = 0;
    int errors = 0;

    logic [39:0] obs;
    logic [2:0]  sc_obs;
    assign obs    = {rf_we, rf_waddr, rf_wdata, rf_zero, rf_overflow};
    assign sc_obs = {mul_stall, dut.fifo_count};

    mult_wb_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .alu_regwrite (alu_regwrite),
        .alu_wreg     (alu_wreg),
        .alu_result   (alu_result),
        .mul_valid    (mul_valid),
        .mul_wreg     (mul_wreg),
        .mul_result   (mul_result),
        .mul_zero     (mul_zero),
        .mul_overflow (mul_overflow),
        .mul_stall    (mul_stall),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .rf_zero      (rf_zero),
        .rf_overflow  (rf_overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [39:0] rfv(input logic we, input logic [4:0] a,
                                        input logic [31:0] d, input logic z, input logic o);
        return {we, a, d, z, o};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_alu(input logic en, input logic [4:0] a, input logic [31:0] d);
        alu_regwrite = en;
        alu_wreg     = a;
        alu_result   = d;
    endtask

    task automatic drive_mul(input logic v, input logic [4:0] a, input logic [31:0] d,
                             input logic z, input logic o);
        mul_valid    = v;
        mul_wreg     = a;
        mul_result   = d;
        mul_zero     = z;
        mul_overflow = o;
    endtask

    task automatic idle();
        drive_alu(1'b0, 5'd0, 32'd0);
        drive_mul(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        logic [39:0] e;
        reset = 1'b1;
        idle();
        step();
        step();
        e = rfv(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        checks++;
        if (obs !== e) begin errors++; $display("FAIL reset_rf got %h exp %h", obs, e); end
        checks++;
        if (sc_obs !== 3'b000) begin errors++; $display("FAIL reset_stall_count got %b exp 000", sc_obs); end
        reset = 1'b0;
        step();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL reset_idle_rf got %h exp %h", obs, e); end
    endtask

    task automatic test_single_mul();
        logic [39:0] e;
        drive_mul(1'b1, 5'd3, 32'h12, 1'b0, 1'b1);
        step();
        idle();
`ifdef MULT_WB_BYPASS_EN
        e = rfv(1'b1, 5'd3, 32'h12, 1'b0, 1'b1);
        checks++;
        if (obs !== e) begin errors++; $display("FAIL bypass_rf got %h exp %h", obs, e); end
        checks++;
        if (sc_obs !== 3'b000) begin errors++; $display("FAIL bypass_count got %b exp 000", sc_obs); end
        step();
        e = rfv(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        checks++;
        if (obs !== e) begin errors++; $display("FAIL bypass_once got %h exp %h", obs, e); end
`else
        e = rfv(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        checks++;
        if (obs !== e) begin errors++; $display("FAIL single_first_rf got %h exp %h", obs, e); end
        checks++;
        if (sc_obs !== 3'b001) begin errors++; $display("FAIL single_push_count got %b exp 001", sc_obs); end
        step();
        e = rfv(1'b1, 5'd3, 32'h12, 1'b0, 1'b1);
        checks++;
        if (obs !== e) begin errors++; $display("FAIL single_pop_rf got %h exp %h", obs, e); end
        checks++;
        if (sc_obs !== 3'b000) begin errors++; $display("FAIL single_pop_count got %b exp 000", sc_obs); end
`endif
        step();
    endtask

    task automatic test_alu_and_mul();
        logic [39:0] e;
        drive_alu(1'b1, 5'd4, 32'hA4);
        drive_mul(1'b1, 5'd5, 32'hB5, 1'b1, 1'b0);
        step();
        idle();
        e = rfv(1'b1, 5'd4, 32'hA4, 1'b0, 1'b0);
        checks++;
        if (obs !== e) begin errors++; $display("FAIL alu_first_rf got %h exp %h", obs, e); end
        checks++;
        if (sc_obs !== 3'b001) begin errors++; $display("FAIL alu_mul_count got %b exp 001", sc_obs); end
        step();
        e = rfv(1'b1, 5'd5, 32'hB5, 1'b1, 1'b0);
        checks++;
        if (obs !== e) begin errors++; $display("FAIL mul_second_rf got %h exp %h", obs, e); end
        step();
        e = rfv(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        checks++;
        if (obs !== e) begin errors++; $display("FAIL alu_mul_idle_rf got %h exp %h", obs, e); end
    endtask

    task automatic test_back_to_back_stall();
        logic [39:0] e;
        drive_alu(1'b1, 5'd6, 32'h66);
        drive_mul(1'b1, 5'd7, 32'h77, 1'b0, 1'b0);
        step();
        e = rfv(1'b1, 5'd6, 32'h66, 1'b0, 1'b0);
        checks++;
        if (obs !== e) begin errors++; $display("FAIL stall_c1_rf got %h exp %h", obs, e); end
        checks++;
        if (sc_obs !== 3'b001) begin errors++; $display("FAIL stall_c1_sc got %b exp 001", sc_obs); end
        drive_mul(1'b1, 5'd8, 32'h88, 1'b0, 1'b1);
        step();
        checks++;
        if (sc_obs !== 3'b110) begin errors++; $display("FAIL stall_c2_sc got %b exp 110", sc_obs); end
        drive_mul(1'b1, 5'd9, 32'h99, 1'b1, 1'b1);
        step();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL stall_c3_rf got %h exp %h", obs, e); end
        checks++;
        if (sc_obs !== 3'b110) begin errors++; $display("FAIL stall_c3_sc got %b exp 110", sc_obs); end
        drive_alu(1'b0, 5'd0, 32'd0);
        step();
        e = rfv(1'b1, 5'd7, 32'h77, 1'b0, 1'b0);
        checks++;
        if (obs !== e) begin errors++; $display("FAIL stall_c4_rf got %h exp %h", obs, e); end
        checks++;
        if (sc_obs !== 3'b001) begin errors++; $display("FAIL stall_c4_sc got %b exp 001", sc_obs); end
        step();
        drive_mul(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        e = rfv(1'b1, 5'd8, 32'h88, 1'b0, 1'b1);
        checks++;
        if (obs !== e) begin errors++; $display("FAIL stall_c5_rf got %h exp %h", obs, e); end
        checks++;
        if (sc_obs !== 3'b001) begin errors++; $display("FAIL stall_c5_sc got %b exp 001", sc_obs); end
        step();
        e = rfv(1'b1, 5'd9, 32'h99, 1'b1, 1'b1);
        checks++;
        if (obs !== e) begin errors++; $display("FAIL stall_c6_rf got %h exp %h", obs, e); end
        checks++;
        if (sc_obs !== 3'b000) begin errors++; $display("FAIL stall_c6_sc got %b exp 000", sc_obs); end
        step();
        e = rfv(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        checks++;
        if (obs !== e) begin errors++; $display("FAIL stall_c7_rf got %h exp %h", obs, e); end
    endtask

    task automatic test_waw_invalidate();
        logic [39:0] e;
        drive_alu(1'b1, 5'd11, 32'hB1);
        drive_mul(1'b1, 5'd10, 32'hA0, 1'b1, 1'b1);
        step();
        drive_mul(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        drive_alu(1'b1, 5'd10, 32'h1234);
        step();
        idle();
        e = rfv(1'b1, 5'd10, 32'h1234, 1'b0, 1'b0);
        checks++;
        if (obs !== e) begin errors++; $display("FAIL waw_alu_rf got %h exp %h", obs, e); end
        checks++;
        if (sc_obs !== 3'b001) begin errors++; $display("FAIL waw_buffered_sc got %b exp 001", sc_obs); end
        step();
        e = rfv(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        checks++;
        if (obs !== e) begin errors++; $display("FAIL waw_stale_pop_rf got %h exp %h", obs, e); end
        checks++;
        if (sc_obs !== 3'b000) begin errors++; $display("FAIL waw_pop_sc got %b exp 000", sc_obs); end
        step();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL waw_after_rf got %h exp %h", obs, e); end
    endtask

    task automatic test_same_addr_and_r0();
        logic [39:0] e;
        drive_alu(1'b1, 5'd2, 32'h22);
        drive_mul(1'b1, 5'd2, 32'h55, 1'b1, 1'b0);
        step();
        idle();
        e = rfv(1'b1, 5'd2, 32'h22, 1'b0, 1'b0);
        checks++;
        if (obs !== e) begin errors++; $display("FAIL same_addr_rf got %h exp %h", obs, e); end
        checks++;
        if (sc_obs !== 3'b000) begin errors++; $display("FAIL same_addr_drop_sc got %b exp 000", sc_obs); end
        step();
        e = rfv(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        checks++;
        if (obs !== e) begin errors++; $display("FAIL same_addr_after_rf got %h exp %h", obs, e); end
        drive_mul(1'b1, 5'd0, 32'h77, 1'b1, 1'b1);
        step();
        idle();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL mul_r0_rf got %h exp %h", obs, e); end
        checks++;
        if (sc_obs !== 3'b000) begin errors++; $display("FAIL mul_r0_sc got %b exp 000", sc_obs); end
        step();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL mul_r0_later_rf got %h exp %h", obs, e); end
        drive_alu(1'b1, 5'd0, 32'h99);
        step();
        idle();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL alu_r0_rf got %h exp %h", obs, e); end
    endtask

    task automatic test_reset_flush();
        logic [39:0] e;
        drive_alu(1'b1, 5'd1, 32'h11);
        drive_mul(1'b1, 5'd12, 32'hC, 1'b0, 1'b0);
        step();
        drive_mul(1'b1, 5'd13, 32'hD, 1'b0, 1'b0);
        step();
        idle();
        checks++;
        if (sc_obs !== 3'b110) begin errors++; $display("FAIL flush_full_sc got %b exp 110", sc_obs); end
        reset = 1'b1;
        step();
        e = rfv(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        checks++;
        if (obs !== e) begin errors++; $display("FAIL flush_rf got %h exp %h", obs, e); end
        checks++;
        if (sc_obs !== 3'b000) begin errors++; $display("FAIL flush_sc got %b exp 000", sc_obs); end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL flush_stale_rf cycle %0d got %h exp %h", i, obs, e); end
        end
    endtask

    initial begin
        test_reset();
        test_single_mul();
        test_alu_and_mul();
        test_back_to_back_stall();
        test_waw_invalidate();
        test_same_addr_and_r0();
        test_reset_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
